btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Debounces the board push-buttons for the CPU board.
- Consumes one bit of the free-running `clkdiv` bus (e.g. `clkdiv[17]`) as a slow sampling reference.
- Produces clean per-button levels, plus one-cycle press and release pulses.
- Sits directly downstream of the clock divider. Feeds single-step CPU clocking, mode select and display-page logic.

Parameters:
- N_BTN, 5, number of button channels.
- STABLE_CNT, 4, consecutive identical samples required to accept a new level (2..15).
- REPEAT_DELAY, 32, samples held before the first auto-repeat pulse (used only with AUTO_REPEAT_EN).
- REPEAT_RATE, 8, samples between subsequent auto-repeat pulses (used only with AUTO_REPEAT_EN).

Ports:
- clk, input, 1, system clock; the same clock that drives the divider counter.
- rst, input, 1, synchronous, active-high reset.
- tick_src, input, 1, one bit of `clkdiv`; each rising edge defines one sample instant.
- btn_in, input, N_BTN, raw asynchronous button levels; active-high.
- btn_level, output, N_BTN, debounced button levels.
- btn_press, output, N_BTN, one-clk pulse per accepted press (and per auto-repeat).
- btn_release, output, N_BTN, one-clk pulse per accepted release.

Behaviour:
- Clocking and reset:
  - One clock, `clk`. Reset `rst` is synchronous and active-high.
  - During and after reset, all outputs are 0, all synchroniser flops are 0, every channel FSM is IDLE and all counters are 0.
- Synchronisation:
  - `tick_src` passes through 3 flops (t1, t2, t3). Sample tick is `tick = t2 & ~t3`, exactly one clk wide.
  - `btn_in` passes through 2 flops per bit, giving `raw`.
- FSM state changes only on cycles where `tick`=1. Outputs are registered.
- Per-channel FSM (2-bit state, 4-bit sample counter `cnt`):
  - IDLE (level 0): raw=1 → DB_PRESS, cnt=1.
  - DB_PRESS:
    - raw=0 → IDLE, cnt=0.
    - raw=1 and cnt==STABLE_CNT-1 → HELD; btn_level=1; btn_press=1 for the next clk only.
    - Otherwise cnt++.
  - HELD (level 1): raw=0 → DB_RELEASE, cnt=1.
  - DB_RELEASE:
    - raw=1 → HELD, cnt=0.
    - raw=0 and cnt==STABLE_CNT-1 → IDLE; btn_level=0; btn_release=1 for the next clk.
    - Otherwise cnt++.
- Latency: a clean edge on `btn_in` is reflected on btn_level/btn_press within 2 clk plus STABLE_CNT ticks plus 1 clk.
- Glitches shorter than STABLE_CNT-1 sample periods produce no output change.
- Channels are fully independent. Simultaneous presses on several channels pulse in the same clk.
- btn_press and btn_release are never asserted together on one channel.
- Reset mid-debounce discards progress. A button held through reset is re-debounced after reset and reports a fresh press.
- `cnt` saturates; it never wraps, because the transition fires at STABLE_CNT-1.

Optional Feature:
- Macro: BTN_DEBOUNCE_AUTO_REPEAT_EN.
- Defined:
  - Each channel has an 8-bit repeat counter that is cleared on entry to HELD and incremented per tick while in HELD.
  - At count REPEAT_DELAY, btn_press pulses once and the counter reloads to REPEAT_DELAY-REPEAT_RATE, giving a pulse every REPEAT_RATE ticks thereafter.
  - btn_level stays 1 throughout. Leaving HELD stops repeats immediately.
- Undefined: no repeat counter exists; exactly one btn_press per accepted press.

Decomposition:
- Shared package / header `btn_pkg`:
  - State encodings: IDLE=2'b00, DB_PRESS=2'b01, HELD=2'b10, DB_RELEASE=2'b11.
  - Counter width constant CNT_W=4.
  - Default STABLE_CNT.
- Sub-module `btn_db_chan`: one channel containing FSM, counter and optional repeat logic; inputs clk, rst, tick, raw.
- The top level owns the synchronisers and tick detection, and generates N_BTN `btn_db_chan` instances.

Test Plan:
- Bench setup: tick_src is a square wave with period 16 clk; STABLE_CNT=4.
- Reset: hold rst=1 for 5 clk with btn_in=5'b11111 → all outputs 0 during reset. After release, btn_level=5'b11111 and one btn_press pulse per channel appear within 4 ticks + 3 clk.
- Clean press and release of btn_in[0] → exactly one btn_press[0] pulse, btn_level[0]=1. Release → exactly one btn_release[0] pulse, btn_level[0]=0. Other channels stay 0.
- Bounce: btn_in[2] toggles 0/1 every 10 clk for 100 clk, then holds 1 → no pulses during bouncing; a single btn_press[2] after 4 stable ticks.
- Glitch: btn_in[1] is high for 2 ticks then low → no btn_press[1], btn_level[1] stays 0.
- Reset mid-operation: assert rst during DB_PRESS (after 2 ticks) → outputs 0. With btn_in still 1, the press is reported only after 4 further ticks.
- Auto-repeat (macro defined, REPEAT_DELAY=32, REPEAT_RATE=8): hold btn_in[3] for 60 ticks after debounce → press pulses at debounce and at hold ticks 32, 40, 48, 56 (5 total). Without the macro → 1 pulse.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer.
// Optional auto-repeat is enabled by defining BTN_DEBOUNCE_AUTO_REPEAT_EN.
package btn_pkg;

    // Per-channel debounce state; bit 1 tracks the accepted level.
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        DB_PRESS   = 2'b01,
        HELD       = 2'b10,
        DB_RELEASE = 2'b11
    } db_state_e;

    localparam int CNT_W          = 4;
    localparam int STABLE_CNT_DEF = 4;

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    localparam int RPT_W = 8;
`endif

endpackage

// File: rtl/btn_db_chan.sv
// One debounce channel: sample FSM, stability counter and registered
// level/press/release outputs. Auto-repeat logic is present only when
// BTN_DEBOUNCE_AUTO_REPEAT_EN is defined.
module btn_db_chan
    import btn_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rls
);

    // Transition fires when the counter reaches this value, so it never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rls_q, rls_d;

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [RPT_W-1:0] rpt_inc;
    assign rpt_inc = rpt_q + RPT_W'(1);
`endif

    // Next-state logic; the FSM only moves on sample ticks, pulses last one clk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rls_d   = 1'b0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
        rpt_d   = rpt_q;
`endif
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (raw) begin
                        state_d = DB_PRESS;
                        cnt_d   = CNT_W'(1);
                    end
                end
                DB_PRESS: begin
                    if (!raw) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                        rpt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!raw) begin
                        state_d = DB_RELEASE;
                        cnt_d   = CNT_W'(1);
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                    end else if (rpt_inc == RPT_FIRE) begin
                        press_d = 1'b1;
                        rpt_d   = RPT_RELOAD;
                    end else begin
                        rpt_d = rpt_inc;
`endif
                    end
                end
                DB_RELEASE: begin
                    if (raw) begin
                        state_d = HELD;
                        cnt_d   = '0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                        rpt_d   = '0;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        rls_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset discards any progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rls_q   <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rls_q   <= rls_d;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rls   = rls_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer top: synchronises the slow clkdiv sampling bit and
// the raw buttons, derives a one-clk sample tick, and runs one independent
// debounce channel per button. Define BTN_DEBOUNCE_AUTO_REPEAT_EN to get
// auto-repeat press pulses while a button is held.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN      = 5,
    parameter int STABLE_CNT = STABLE_CNT_DEF
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_src,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    logic             t1_q, t2_q, t3_q;
    logic             t1_d, t2_d, t3_d;
    logic [N_BTN-1:0] s1_q, s2_q;
    logic [N_BTN-1:0] s1_d, s2_d;
    logic             tick;

    // Synchroniser chains: t3 is the delayed copy used for edge detection.
    always_comb begin
        t1_d = tick_src;
        t2_d = t1_q;
        t3_d = t2_q;
        s1_d = btn_in;
        s2_d = s1_q;
    end

    // Synchroniser flops, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            t1_q <= 1'b0;
            t2_q <= 1'b0;
            t3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            t1_q <= t1_d;
            t2_q <= t2_d;
            t3_q <= t3_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Rising edge of the synchronised divider bit: one clk wide.
    assign tick = t2_q & ~t3_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_db_chan #(
            .STABLE_CNT   (STABLE_CNT)
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
`endif
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .raw   (s2_q[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rls   (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: tick_src period 16 clk, STABLE_CNT=4.
// Expected repeat count depends on BTN_DEBOUNCE_AUTO_REPEAT_EN.
module tb_btn_debounce;

    localparam int N = 5;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    localparam int EXP_RPT = 5;
`else
    localparam int EXP_RPT = 1;
`endif

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         tick_src = 1'b0;
    logic [N-1:0] btn_in   = '0;
    logic [N-1:0] btn_level, btn_press, btn_release;

    int n_chk = 0;
    int n_bad = 0;
    int press_cnt [N] = '{default: 0};
    int rel_cnt   [N] = '{default: 0};
    int overlap       = 0;
    int pb [N];
    int rb [N];

    btn_debounce #(.N_BTN(N), .STABLE_CNT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_src   (tick_src),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Slow sampling reference: toggles every 8 clk, changes on falling clk.
    initial begin
        forever begin
            repeat (8) @(negedge clk);
            tick_src = ~tick_src;
        end
    end

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (btn_press[i])   press_cnt[i] <= press_cnt[i] + 1;
            if (btn_release[i]) rel_cnt[i]   <= rel_cnt[i] + 1;
            if (btn_press[i] && btn_release[i]) overlap <= overlap + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge tick_src);
        clks(6);
    endtask

    task automatic snap();
        pb = press_cnt;
        rb = rel_cnt;
    endtask

    function automatic int pd(input int ch);
        return press_cnt[ch] - pb[ch];
    endfunction

    function automatic int rd(input int ch);
        return rel_cnt[ch] - rb[ch];
    endfunction

    function automatic int pd_others(input int ch);
        int s = 0;
        for (int i = 0; i < N; i++) if (i != ch) s += pd(i);
        return s;
    endfunction

    task automatic wait_level(input logic [N-1:0] exp, input int budget, output int used);
        used = 0;
        while (btn_level !== exp && used < budget) begin
            clks(1);
            used++;
        end
    endtask

    initial begin
        int used;
        logic [N-1:0] ok;

        // reset with all buttons held
        btn_in = '1;
        rst    = 1'b1;
        clks(5);
        chk("rst_level",   btn_level,   '0);
        chk("rst_press",   btn_press,   '0);
        chk("rst_release", btn_release, '0);
        rst = 1'b0;
        wait_level('1, 120, used);
        chk("rst_rel_level", btn_level, 5'h1f);
        chk("rst_rel_latency", used <= 70, 1);
        clks(2);
        for (int i = 0; i < N; i++) ok[i] = (press_cnt[i] == 1);
        chk("rst_rel_press_each", ok, 5'h1f);

        // release everything
        btn_in = '0;
        wait_level('0, 120, used);
        chk("all_rel_level", btn_level, '0);
        clks(2);
        for (int i = 0; i < N; i++) ok[i] = (rel_cnt[i] == 1);
        chk("all_rel_pulse_each", ok, 5'h1f);

        // clean press / release on channel 0
        snap();
        btn_in[0] = 1'b1;
        ticks(8);
        chk("p0_level",  btn_level, 5'h01);
        chk("p0_press",  pd(0), 1);
        chk("p0_others", pd_others(0), 0);
        btn_in[0] = 1'b0;
        ticks(8);
        chk("r0_level",   btn_level, '0);
        chk("r0_release", rd(0), 1);
        chk("r0_press",   pd(0), 1);

        // bounce on channel 2: 10 clk segments for 100 clk, then hold
        snap();
        for (int k = 0; k < 10; k++) begin
            btn_in[2] = (k % 2 == 0);
            clks(10);
        end
        chk("bnc_quiet_press", pd(2), 0);
        chk("bnc_quiet_level", btn_level[2], 0);
        btn_in[2] = 1'b1;
        ticks(8);
        chk("bnc_press", pd(2), 1);
        chk("bnc_level", btn_level[2], 1);
        btn_in[2] = 1'b0;
        ticks(8);
        chk("bnc_rel_level", btn_level, '0);

        // glitch on channel 1 lasting two tick periods
        snap();
        @(posedge tick_src);
        clks(1);
        btn_in[1] = 1'b1;
        repeat (2) @(posedge tick_src);
        clks(1);
        btn_in[1] = 1'b0;
        ticks(8);
        chk("glitch_press", pd(1), 0);
        chk("glitch_level", btn_level[1], 0);

        // reset while channel 4 is one sample short of accepting
        snap();
        @(posedge tick_src);
        btn_in[4] = 1'b1;
        repeat (2) @(posedge tick_src);
        @(negedge tick_src);
        clks(2);
        rst = 1'b1;
        clks(3);
        chk("mid_rst_level", btn_level, '0);
        chk("mid_rst_press", pd(4), 0);
        rst = 1'b0;
        repeat (3) @(posedge tick_src);
        clks(6);
        chk("mid_early", pd(4), 0);
        @(posedge tick_src);
        clks(6);
        chk("mid_press", pd(4), 1);
        chk("mid_level", btn_level, 5'h10);
        btn_in[4] = 1'b0;
        ticks(8);
        chk("mid_rel", rd(4), 1);

        // long hold on channel 3: auto-repeat when enabled
        snap();
        btn_in[3] = 1'b1;
        used = 0;
        while (pd(3) == 0 && used < 120) begin
            clks(1);
            used++;
        end
        chk("rpt_first", pd(3), 1);
        ticks(60);
        chk("rpt_count", pd(3), EXP_RPT);
        chk("rpt_level", btn_level, 5'h08);
        btn_in[3] = 1'b0;
        ticks(8);
        chk("rpt_rel_level", btn_level, '0);
        chk("rpt_rel_press", pd(3), EXP_RPT);
        chk("rpt_rel_pulse", rd(3), 1);

        chk("no_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
